// File: rtl/adder_pipe_pkg.sv
// ============================================================================
// Module : adder_pipe_pkg
// Brief  : Default geometry, result record and parameter legality helper
//          for the segmented pipelined adder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package adder_pipe_pkg;

  localparam int c_width_def  = 32;
  localparam int c_stages_def = 2;
  localparam int c_block_def  = 4;

  typedef struct packed {
    logic [c_width_def-1:0] s;
    logic                   co;
    logic                   ovf;
  } result_t;

  function automatic bit params_legal(input int width, input int stages, input int block);
    if (width < 1 || stages < 1 || block < 1) return 1'b0;
    if ((width % stages) != 0) return 1'b0;
    return ((width / stages) % block) == 0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_pipe_cla_seg.sv
// ============================================================================
// Module : cla_seg
// Brief  : Combinational SEG-bit carry-lookahead adder built from BLOCK-bit
//          lookahead groups, group generate/propagate rippled between groups.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cla_seg #(
  parameter int SEG   = 16,
  parameter int BLOCK = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           cmsb
);

  localparam int c_groups = SEG / BLOCK;

  logic [SEG-1:0]      w_g;
  logic [SEG-1:0]      w_p;
  logic [SEG-1:0]      w_c;
  logic [c_groups-1:0] w_grp_g;
  logic [c_groups-1:0] w_grp_p;
  logic [c_groups:0]   w_gc;

  // Flattened sum-of-products carry into bit n of a group from the group carry-in.
  function automatic logic lookahead(input logic [BLOCK-1:0] gv, input logic [BLOCK-1:0] pv,
                                     input logic c0, input int n);
    logic acc;
    logic term;
    acc = c0;
    for (int m = 0; m < BLOCK; m++)
      if (m < n) acc = acc & pv[m];
    for (int m = 0; m < BLOCK; m++) begin
      if (m < n) begin
        term = gv[m];
        for (int q = m + 1; q < BLOCK; q++)
          if (q < n) term = term & pv[q];
        acc = acc | term;
      end
    end
    return acc;
  endfunction

  assign w_g = a & b;
  assign w_p = a ^ b;

  for (genvar j = 0; j < c_groups; j++) begin : g_grp
    logic [BLOCK-1:0] w_gg;
    logic [BLOCK-1:0] w_pp;

    assign w_gg       = w_g[j*BLOCK +: BLOCK];
    assign w_pp       = w_p[j*BLOCK +: BLOCK];
    assign w_grp_g[j] = lookahead(w_gg, w_pp, 1'b0, BLOCK);
    assign w_grp_p[j] = &w_pp;

    for (genvar i = 0; i < BLOCK; i++) begin : g_bit
      assign w_c[j*BLOCK + i] = lookahead(w_gg, w_pp, w_gc[j], i);
    end
  end

  always_comb begin
    w_gc    = '0;
    w_gc[0] = cin;
    for (int j = 0; j < c_groups; j++)
      w_gc[j+1] = w_grp_g[j] | (w_grp_p[j] & w_gc[j]);
  end

  assign s    = w_p ^ w_c;
  assign cout = w_gc[c_groups];
  assign cmsb = w_c[SEG-1];

endmodule

`default_nettype wire

// File: rtl/adder_pipe.sv
// ============================================================================
// Module : adder_pipe
// Brief  : Valid/ready pipelined adder/subtractor, one operand segment per
//          stage. Define ADDER_PIPE_OVF_EN to build signed-overflow output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = c_width_def,
  parameter int STAGES = c_stages_def,
  parameter int BLOCK  = c_block_def
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             co,
  output logic             ovf
);

  localparam int c_seg  = WIDTH / STAGES;
  localparam int c_last = STAGES - 1;

  if (!params_legal(WIDTH, STAGES, BLOCK)) begin : g_param_check
    $error("adder_pipe: WIDTH must divide by STAGES and WIDTH/STAGES by BLOCK");
  end

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin0;

  assign w_b_eff = sub ? ~B : B;
  assign w_cin0  = sub | ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed when entering stage k.
    localparam int c_rem = WIDTH - k * c_seg;

    logic [c_rem-1:0]       w_src_a;
    logic [c_rem-1:0]       w_src_b;
    logic                   w_cin;
    logic                   w_up_valid;
    logic                   w_free;
    logic                   w_take;
    logic [c_seg-1:0]       w_s;
    logic                   w_cout;
    logic                   w_cmsb;
    logic                   r_v;
    logic                   r_c;
    logic [(k+1)*c_seg-1:0] r_s;

    cla_seg #(
      .SEG   (c_seg),
      .BLOCK (BLOCK)
    ) u_cla (
      .a    (w_src_a[c_seg-1:0]),
      .b    (w_src_b[c_seg-1:0]),
      .cin  (w_cin),
      .s    (w_s),
      .cout (w_cout),
      .cmsb (w_cmsb)
    );

    if (k == 0) begin : g_head
      assign w_src_a    = A;
      assign w_src_b    = w_b_eff;
      assign w_cin      = w_cin0;
      assign w_up_valid = in_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_s <= '0;
        else if (w_take) r_s <= w_s;
      end
    end else begin : g_tail
      assign w_src_a    = g_stage[k-1].g_skew.r_a;
      assign w_src_b    = g_stage[k-1].g_skew.r_b;
      assign w_cin      = g_stage[k-1].r_c;
      assign w_up_valid = g_stage[k-1].r_v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_s <= '0;
        else if (w_take) r_s <= {w_s, g_stage[k-1].r_s};
      end
    end

    assign w_take = w_up_valid & w_free;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
      end else begin
        if (w_free) r_v <= w_take;
        if (w_take) r_c <= w_cout;
      end
    end

    if (k < c_last) begin : g_skew
      logic [c_rem-c_seg-1:0] r_a;
      logic [c_rem-c_seg-1:0] r_b;
      logic                   w_cmsb_unused;

      assign w_free        = !r_v | g_stage[k+1].w_free;
      assign w_cmsb_unused = w_cmsb;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_take) begin
          r_a <= w_src_a[c_rem-1:c_seg];
          r_b <= w_src_b[c_rem-1:c_seg];
        end
      end
    end else begin : g_final
      assign w_free = !r_v | out_ready;
`ifdef ADDER_PIPE_OVF_EN
      logic r_ovf;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_ovf <= 1'b0;
        else if (w_take) r_ovf <= w_cmsb ^ w_cout;
      end
`else
      logic w_cmsb_unused;

      assign w_cmsb_unused = w_cmsb;
`endif
    end
  end

  assign in_ready  = g_stage[0].w_free;
  assign out_valid = g_stage[c_last].r_v;
  assign S         = g_stage[c_last].r_s;
  assign co        = g_stage[c_last].r_c;

`ifdef ADDER_PIPE_OVF_EN
  assign ovf = g_stage[c_last].g_final.r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_pipe.sv
// ============================================================================
// Module : tb_adder_pipe
// Brief  : Scoreboard bench for adder_pipe (WIDTH=32, STAGES=2, BLOCK=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_adder_pipe;
  import adder_pipe_pkg::*;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         co;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit lat_chk = 1'b0;

  typedef struct {
    result_t r;
    int      acc;
    bit      lat;
  } entry_t;

  entry_t sb[$];

  adder_pipe #(
    .WIDTH  (W),
    .STAGES (2),
    .BLOCK  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .co        (co),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic result_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic c, input logic s);
    result_t         r;
    longint unsigned ua, ub, full;
    longint          sa, sbv, res;
    ua  = 64'(a);
    ub  = 64'(b);
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (s) begin
      full = ua - ub;
      r.co = (ua >= ub);
      res  = sa - sbv;
    end else begin
      full = ua + ub + 64'(c);
      r.co = full[W];
      res  = sa + sbv + longint'(c);
    end
    r.s   = full[W-1:0];
    r.ovf = (res > longint'(32'h7fffffff)) || (res < -longint'(32'h80000000));
`ifndef ADDER_PIPE_OVF_EN
    r.ovf = 1'b0;
`endif
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Acceptance side: push expected result at every handshake.
  always @(negedge clk) begin
    entry_t e;
    if (!rst && in_valid && in_ready) begin
      e.r   = model(A, B, ci, sub);
      e.acc = cyc;
      e.lat = lat_chk;
      sb.push_back(e);
    end
  end

  // Output side: pop and compare on every retired result; check hold under stall.
  logic         stall_seen = 1'b0;
  logic [W+1:0] held;

  always @(negedge clk) begin
    entry_t e;
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen)
        check("stall_hold", {out_valid, S, co, ovf}, {1'b1, held});
      stall_seen = out_valid && !out_ready;
      held       = {S, co, ovf};
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got S=0x%0h with nothing outstanding, required no output", S);
        end else begin
          e = sb.pop_front();
          check("result", {S, co, ovf}, {e.r.s, e.r.co, e.r.ovf});
          if (e.lat) check("latency", 64'(cyc - e.acc), 64'(LAT));
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    int n;
    n        = 0;
    A        = a;
    B        = b;
    ci       = c;
    sub      = s;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required acceptance", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation still running, required completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    A         = '0;
    B         = '0;
    ci        = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, S, co, ovf}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Directed corner cases, first one accepted on the first edge after reset.
    lat_chk = 1'b1;
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h5, 32'h7, 1'b0, 1'b1);
    send(32'h5, 32'h7, 1'b1, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    drain();

    // Back-to-back random burst at full throughput.
    c0 = cyc;
    for (int i = 0; i < 100; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("burst_cycles", 64'(cyc - c0), 64'd100);
    drain();

    // Full pipeline held for 5 cycles.
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    send($urandom, $urandom, 1'b0, 1'b0);
    send($urandom, $urandom, 1'b1, 1'b0);
    fork
      send($urandom, $urandom, 1'b0, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("in_ready_full", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send($urandom, $urandom, 1'b1, 1'b1);
    drain();

    // Random backpressure.
    fork
      for (int i = 0; i < 60; i++)
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      begin
        repeat (150) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with two transactions in flight.
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_pipe.md
ADDER_PIPE -- requirements
Module: adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 2, pipeline depth; WIDTH divisible by STAGES.
REQ-003 SHALL have parameter BLOCK, default 4, CLA group width; WIDTH/STAGES divisible by BLOCK.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, operand presented.
REQ-007 SHALL have port in_ready, output, 1, operand accepted this cycle when high with in_valid.
REQ-008 SHALL have ports A and B, input, WIDTH, operands.
REQ-009 SHALL have port ci, input, 1, carry-in (add mode only).
REQ-010 SHALL have port sub, input, 1, 1 = subtract A-B, 0 = add A+B+ci.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-013 SHALL have port S, output, WIDTH, sum/difference mod 2^WIDTH.
REQ-014 SHALL have port co, output, 1, carry-out of MSB (subtract: 1 = no borrow).
REQ-015 SHALL have port ovf, output, 1, two's-complement signed overflow (see REQ-030).

Function
REQ-016 SHALL split operands into STAGES segments of SEG=WIDTH/STAGES bits; stage k adds segment k (LSB first) with carry registered from stage k-1.
REQ-017 SHALL, within a segment, compute carries by BLOCK-bit CLA groups with group G/P rippled between groups.
REQ-018 SHALL in subtract mode add ~B with carry-in forced 1; ci ignored.
REQ-019 SHALL skew-register unprocessed upper operand segments and delay-register completed lower sum segments so all WIDTH bits of one transaction emerge together.
REQ-020 SHALL have latency exactly STAGES cycles from acceptance to out_valid with no backpressure.
REQ-021 SHALL sustain one transaction per cycle when out_ready held high.
REQ-022 SHALL hold each stage (valid bit, data, carry) when its downstream stage is occupied and not advancing; in_ready = !stage0_valid | stage0_advances.
REQ-023 SHALL hold S, co, ovf stable while out_valid=1 and out_ready=0.
REQ-024 SHALL, when full and out_ready=1 with in_valid=1, retire the output and accept the new operand in the same cycle (no bubble).
REQ-025 SHALL never drop, duplicate or reorder transactions.
REQ-026 SHALL allow in_ready to depend combinationally on out_ready; no combinational path from in_valid to out_valid.

Reset
REQ-027 SHALL on rst clear all stage valid bits, drive out_valid=0, S=0, co=0, ovf=0, in_ready=1 after release.
REQ-028 SHALL on rst asserted mid-operation discard all in-flight transactions immediately (asynchronously).
REQ-029 SHALL accept a new operand in the first clock edge after rst deasserts.

Configuration
REQ-030 SHALL, with macro ADDER_PIPE_OVF_EN defined, compute ovf = carry into MSB XOR carry out of MSB, pipelined with its transaction.
REQ-031 SHALL, without ADDER_PIPE_OVF_EN, tie ovf to 0 and instantiate no overflow logic.

Structure
REQ-032 SHALL place default WIDTH/STAGES/BLOCK constants and a result struct (S, co, ovf) typedef in package adder_pipe_pkg.
REQ-033 SHALL use one sub-module cla_seg: parametrised SEG-bit, BLOCK-grouped combinational CLA with inputs a, b, cin and outputs s, cout, cmsb (carry into MSB).
REQ-034 SHALL reject illegal parameter combinations with an elaboration-time error.

Verification (WIDTH=32, STAGES=2, BLOCK=4, OVF_EN defined)
REQ-035 SHALL test: A=0xFFFFFFFF, B=1, ci=0, sub=0 -> after 2 cycles S=0, co=1, ovf=0.
REQ-036 SHALL test: A=0x7FFFFFFF, B=1, sub=0 -> S=0x80000000, co=0, ovf=1; A=5, B=7, sub=1 -> S=0xFFFFFFFE, co=0, ovf=0.
REQ-037 SHALL test: back-to-back 100 random ops, out_ready=1 -> one result per cycle, in order, matching A+B+ci / A-B.
REQ-038 SHALL test: out_ready=0 for 5 cycles with pipeline full -> in_ready=0 after 2 accepts, S held; release -> remaining results in order, none lost.
REQ-039 SHALL test: rst pulsed with 2 ops in flight -> out_valid=0 immediately, no stale result after release, next op returns correctly in 2 cycles.
REQ-040 SHALL test: build without ADDER_PIPE_OVF_EN, A=0x7FFFFFFF, B=1 -> S=0x80000000, ovf=0.
